agc_gain_ctrl: RTL and testbench
================================

# agc_gain_ctrl

- Closed-loop gain controller for the AGC chain.
- Sits directly downstream of the I/Q envelope approximator and consumes its 12-bit unsigned magnitude stream.
- Averages the envelope over a fixed power-of-two window and compares the average against a programmable target with hysteresis.
- Steps a gain word down quickly (attack) or up slowly (decay), clamped to limits; reports lock and saturation status.

## Interface
- LOG2_WIN, 4: log2 of averaging window length (window = 2^LOG2_WIN accepted samples)
- GW, 10: gain word width
- GAIN_INIT, 512: gain value after reset
- GAIN_MIN, 0: lower gain clamp
- GAIN_MAX, 1023: upper gain clamp
- ATTACK_STEP, 16: gain decrement when average is above band
- DECAY_STEP, 2: gain increment when average is below band
- LOCK_CNT, 4: consecutive in-band windows required to assert locked
- i_clk  in  1  system clock (100 MHz)
- i_rst  in  1  reset; synchronous, active-low
- env_in  in  12  envelope magnitude, unsigned
- env_valid  in  1  env_in qualifier, one sample per high cycle
- target  in  12  desired average envelope, unsigned
- hyst  in  12  half-width of dead band, unsigned
- freeze  in  1  inhibit gain and lock updates
- gain  out  GW  current gain word
- gain_valid  out  1  one-cycle pulse at every window decision
- locked  out  1  loop settled
- sat_hi  out  1  gain == GAIN_MAX
- sat_lo  out  1  gain == GAIN_MIN

## Operation
- States:
  - ACC: while env_valid is high, add env_in to the accumulator (12+LOG2_WIN bits, no overflow possible) and increment the sample counter. On acceptance of sample 2^LOG2_WIN, go to EVAL.
  - EVAL: avg = acc >> LOG2_WIN (truncate). Compute upper = min(target+hyst, 4095) using 13-bit addition. Compute lower = max(target−hyst, 0). Register the decision: HIGH if avg > upper, LOW if avg < lower, else IN. Clear the accumulator and counter. Go to UPD.
  - UPD: apply the decision, pulse gain_valid, return to ACC.
- env_valid in EVAL/UPD is ignored and those samples are dropped; they do not count toward the next window.
- Gain update in UPD, when freeze=0:
  - HIGH: gain = (gain < GAIN_MIN+ATTACK_STEP) ? GAIN_MIN : gain−ATTACK_STEP
  - LOW: gain = (gain > GAIN_MAX−DECAY_STEP) ? GAIN_MAX : gain+DECAY_STEP
  - IN: gain unchanged
  - Compare in GW+1 bits so the clamp arithmetic cannot wrap.
- Lock counter, when freeze=0:
  - IN increments the counter, saturating at LOCK_CNT.
  - HIGH or LOW clears it.
  - locked = (counter == LOCK_CNT), registered and updated in UPD.
- Freeze:
  - freeze=1 sampled in UPD leaves gain, lock counter and locked unchanged; gain_valid still pulses.
  - Averaging continues regardless of freeze.
- sat_hi and sat_lo are registered and updated in the same cycle as gain; both reflect the new gain value.
- target and hyst are sampled only in EVAL; changes mid-window take effect at the next decision.

## Timing
- Reset (i_rst=0 at a rising edge):
  - gain=GAIN_INIT, gain_valid=0, locked=0, lock counter=0, accumulator=0, sample counter=0, state=ACC.
  - sat_hi/sat_lo = (GAIN_INIT==GAIN_MAX)/(GAIN_INIT==GAIN_MIN).
- Reset overrides all other inputs. Reset mid-window discards the partial sum; reset during EVAL/UPD cancels the pending update.
- Latency: last window sample accepted at edge t → EVAL at t+1 → gain, sat flags, locked updated and gain_valid=1 at edge t+2. gain_valid is low at t+3.
- Continuous env_valid gives one decision per 2^LOG2_WIN+2 cycles.
- gain holds its value between updates; downstream may sample it at any time.

## Test plan
- Reset: hold i_rst=0 for 3 cycles with env_valid toggling → gain=512, gain_valid=0, locked=0, sat_hi=0, sat_lo=0; no gain_valid until 16 samples are accepted after release.
- Attack: target=1024, hyst=64, 16 samples of 2000 → gain=496, gain_valid exactly 2 cycles after the 16th sample; 2 samples presented in EVAL/UPD are dropped (the next decision needs 16 new samples).
- Decay and clamp: 16 samples of 100 → gain=514.
- Lower clamp: repeated windows of 4095 → gain reaches 0 after 32 windows; sat_lo=1; further windows hold gain at 0.
- Lock:
  - 4 windows of 1024 → gain stays 512 and locked rises with the 4th gain_valid.
  - A following window of 1200 → gain=496, locked=0.
  - The next 3 in-band windows keep locked=0.
- Freeze and band edge:
  - freeze=1 with a window of 2000 → gain_valid pulses, gain unchanged.
  - target=4090, hyst=64, env 4095 → upper saturates at 4095, decision IN, gain unchanged.
  - Reset after 8 samples → following decision uses only post-reset samples.

Source files
------------

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain controller: averages a window of envelope samples, compares the
// average against target +/- hyst and steps the gain down fast (attack) or up slow (decay).
module agc_gain_ctrl #(
    parameter int LOG2_WIN    = 4,
    parameter int GW          = 10,
    parameter int GAIN_INIT   = 512,
    parameter int GAIN_MIN    = 0,
    parameter int GAIN_MAX    = 1023,
    parameter int ATTACK_STEP = 16,
    parameter int DECAY_STEP  = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [11:0]   env_in,
    input  logic          env_valid,
    input  logic [11:0]   target,
    input  logic [11:0]   hyst,
    input  logic          freeze,
    output logic [GW-1:0] gain,
    output logic          gain_valid,
    output logic          locked,
    output logic          sat_hi,
    output logic          sat_lo,
    output logic [1:0]    dbg_state
);

    // Stream semantics: env_in is consumed on every rising edge where env_valid is high
    // and the controller is accumulating; there is no ready, samples arriving during
    // the two decision cycles are dropped. gain_valid is a one-cycle strobe per decision.

    localparam int AW = 12 + LOG2_WIN;
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic [GW:0]         MIN_W    = (GW+1)'(GAIN_MIN);
    localparam logic [GW:0]         MAX_W    = (GW+1)'(GAIN_MAX);
    localparam logic [GW:0]         ATK_W    = (GW+1)'(ATTACK_STEP);
    localparam logic [GW:0]         DEC_W    = (GW+1)'(DECAY_STEP);
    localparam logic [GW-1:0]       MIN_G    = GW'(GAIN_MIN);
    localparam logic [GW-1:0]       MAX_G    = GW'(GAIN_MAX);
    localparam logic [GW-1:0]       INIT_G   = GW'(GAIN_INIT);
    localparam logic [LW-1:0]       LOCK_W   = LW'(LOCK_CNT);
    localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_EVAL = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        D_IN   = 2'd0,
        D_HIGH = 2'd1,
        D_LOW  = 2'd2
    } dec_t;

    state_t              state, state_nxt;
    dec_t                dec, dec_nxt;
    logic [AW-1:0]       acc;
    logic [LOG2_WIN-1:0] cnt;
    logic [LW-1:0]       lock_cnt, lock_upd;
    logic [11:0]         avg, upper, lower;
    logic [12:0]         sum13;
    logic [GW:0]         g_ext;
    logic [GW-1:0]       gain_upd;

    assign dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= S_ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC:   if (env_valid && cnt == CNT_LAST) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_UPD;
            S_UPD:   state_nxt = S_ACC;
            default: state_nxt = S_ACC;
        endcase
    end

    // Dead band: upper saturates at full scale, lower floors at zero.
    always_comb begin
        avg   = acc[AW-1:LOG2_WIN];
        sum13 = {1'b0, target} + {1'b0, hyst};
        upper = sum13[12] ? 12'hFFF : sum13[11:0];
        lower = (target > hyst) ? (target - hyst) : 12'd0;
        if (avg > upper)      dec_nxt = D_HIGH;
        else if (avg < lower) dec_nxt = D_LOW;
        else                  dec_nxt = D_IN;
    end

    // Clamp tests run one bit wider so the limit arithmetic cannot wrap; the GW-bit
    // add/subtract below is only taken when the wide test proves it stays in range.
    always_comb begin
        g_ext    = {1'b0, gain};
        gain_upd = gain;
        lock_upd = '0;
        case (dec)
            D_HIGH: gain_upd = (g_ext < MIN_W + ATK_W) ? MIN_G : (gain - GW'(ATTACK_STEP));
            D_LOW:  gain_upd = (g_ext + DEC_W > MAX_W) ? MAX_G : (gain + GW'(DECAY_STEP));
            default: begin
                gain_upd = gain;
                lock_upd = (lock_cnt == LOCK_W) ? lock_cnt : (lock_cnt + 1'b1);
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            acc        <= '0;
            cnt        <= '0;
            dec        <= D_IN;
            gain       <= INIT_G;
            gain_valid <= 1'b0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
            sat_hi     <= (GAIN_INIT == GAIN_MAX);
            sat_lo     <= (GAIN_INIT == GAIN_MIN);
        end else begin
            gain_valid <= 1'b0;
            case (state)
                S_ACC: begin
                    if (env_valid) begin
                        acc <= acc + {{LOG2_WIN{1'b0}}, env_in};
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    dec <= dec_nxt;
                    acc <= '0;
                    cnt <= '0;
                end
                S_UPD: begin
                    gain_valid <= 1'b1;
                    if (!freeze) begin
                        gain     <= gain_upd;
                        sat_hi   <= (gain_upd == MAX_G);
                        sat_lo   <= (gain_upd == MIN_G);
                        lock_cnt <= lock_upd;
                        locked   <= (lock_upd == LOCK_W);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Self-checking bench for agc_gain_ctrl: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a window-level behavioural model.
module tb_agc_gain_ctrl;

    localparam int LOG2_WIN    = 4;
    localparam int WIN         = 1 << LOG2_WIN;
    localparam int GW          = 10;
    localparam int GAIN_INIT   = 512;
    localparam int GAIN_MIN    = 0;
    localparam int GAIN_MAX    = 1023;
    localparam int ATTACK_STEP = 16;
    localparam int DECAY_STEP  = 2;
    localparam int LOCK_CNT    = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [11:0]   env_in = '0;
    logic          env_valid = 1'b0;
    logic [11:0]   target = '0;
    logic [11:0]   hyst = '0;
    logic          freeze = 1'b0;
    logic [GW-1:0] gain;
    logic          gain_valid, locked, sat_hi, sat_lo;
    logic [1:0]    dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: window sum/sample count, decision pipeline, gain, lock.
    int m_gain, m_lock, m_sum, m_n, m_busy, m_dec;
    bit m_gv, m_locked;
    int win_cycles;

    agc_gain_ctrl #(
        .LOG2_WIN(LOG2_WIN), .GW(GW), .GAIN_INIT(GAIN_INIT), .GAIN_MIN(GAIN_MIN),
        .GAIN_MAX(GAIN_MAX), .ATTACK_STEP(ATTACK_STEP), .DECAY_STEP(DECAY_STEP),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .env_in(env_in), .env_valid(env_valid),
        .target(target), .hyst(hyst), .freeze(freeze), .gain(gain),
        .gain_valid(gain_valid), .locked(locked), .sat_hi(sat_hi), .sat_lo(sat_lo),
        .dbg_state(dbg_state)
    );

    always #5 i_clk = ~i_clk;

    // Window-level model, evaluated with the inputs present at each rising edge.
    task automatic model_edge();
        int avg, up, lo;
        if (!i_rst) begin
            m_gain = GAIN_INIT; m_lock = 0; m_locked = 0; m_gv = 0;
            m_sum = 0; m_n = 0; m_busy = 0; m_dec = 0;
        end else begin
            m_gv = 0;
            if (m_busy == 2) begin
                avg = m_sum / WIN;
                up  = int'(target) + int'(hyst);
                if (up > 4095) up = 4095;
                lo  = int'(target) - int'(hyst);
                if (lo < 0) lo = 0;
                m_dec  = (avg > up) ? 1 : ((avg < lo) ? 2 : 0);
                m_sum  = 0; m_n = 0; m_busy = 1;
            end else if (m_busy == 1) begin
                m_gv = 1; m_busy = 0;
                if (!freeze) begin
                    if (m_dec == 1) begin
                        m_gain = m_gain - ATTACK_STEP;
                        if (m_gain < GAIN_MIN) m_gain = GAIN_MIN;
                        m_lock = 0;
                    end else if (m_dec == 2) begin
                        m_gain = m_gain + DECAY_STEP;
                        if (m_gain > GAIN_MAX) m_gain = GAIN_MAX;
                        m_lock = 0;
                    end else if (m_lock < LOCK_CNT) begin
                        m_lock = m_lock + 1;
                    end
                    m_locked = (m_lock == LOCK_CNT);
                end
            end else if (env_valid) begin
                m_sum = m_sum + int'(env_in);
                m_n   = m_n + 1;
                if (m_n == WIN) m_busy = 2;
            end
        end
    endtask

    function automatic logic [GW+3:0] exp_vec();
        return {GW'(m_gain), m_gv, m_locked, m_gain == GAIN_MAX, m_gain == GAIN_MIN};
    endfunction

    task automatic step(input logic v, input logic [11:0] e);
        env_valid = v;
        env_in    = e;
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        i_rst  = 1'b0;
        freeze = 1'b0;
        step(1'b0, 12'd0);
        step(1'b0, 12'd0);
        i_rst = 1'b1;
    endtask

    // Feed n windows of a constant envelope, checking every cycle; stops at each gain_valid.
    task automatic run_windows(input string name, input int n, input logic [11:0] e);
        for (int w = 0; w < n; w++) begin
            win_cycles = 0;
            while (1) begin
                step(1'b1, e);
                win_cycles++;
                vectors++;
                if ({gain, gain_valid, locked, sat_hi, sat_lo} !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL %s w%0d: gain/gv/lk/hi/lo got %h want %h", name, w,
                             {gain, gain_valid, locked, sat_hi, sat_lo}, exp_vec());
                end
                if (gain_valid === 1'b1) break;
                if (win_cycles > 3 * WIN) begin
                    miscompares++;
                    $display("FAIL %s w%0d: no gain_valid got 0 want 1 within %0d cycles",
                             name, w, win_cycles);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(i[0], 12'd3000);
            vectors++;
            if ({gain, gain_valid, locked, sat_hi, sat_lo} !== {10'd512, 4'b0000}) begin
                miscompares++;
                $display("FAIL reset c%0d: gain/gv/lk/hi/lo got %h want %h", i,
                         {gain, gain_valid, locked, sat_hi, sat_lo}, {10'd512, 4'b0000});
            end
        end
        i_rst = 1'b1;
        target = 12'd1024;
        hyst   = 12'd64;
        for (int i = 0; i < WIN - 1; i++) begin
            step(1'b1, 12'd3000);
            vectors++;
            if (gain_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_early_gv s%0d: got %b want 0", i, gain_valid);
            end
        end
        run_windows("reset_first", 1, 12'd3000);
        vectors++;
        if (win_cycles != 3) begin
            miscompares++;
            $display("FAIL reset_first_len: got %0d want 3", win_cycles);
        end
    endtask

    task automatic test_attack();
        do_reset();
        target = 12'd1024;
        hyst   = 12'd64;
        run_windows("attack", 1, 12'd2000);
        vectors++;
        if (gain !== 10'd496 || win_cycles != WIN + 2) begin
            miscompares++;
            $display("FAIL attack: gain %0d len %0d want 496 len %0d", gain, win_cycles, WIN + 2);
        end
        run_windows("attack_next", 1, 12'd1024);
        vectors++;
        if (win_cycles != WIN + 2 || gain !== 10'd496) begin
            miscompares++;
            $display("FAIL attack_drop: len %0d gain %0d want %0d 496", win_cycles, gain, WIN + 2);
        end
    endtask

    task automatic test_decay();
        do_reset();
        target = 12'd1024;
        hyst   = 12'd64;
        run_windows("decay", 1, 12'd100);
        vectors++;
        if (gain !== 10'd514) begin
            miscompares++;
            $display("FAIL decay: gain got %0d want 514", gain);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        target = 12'd1024;
        hyst   = 12'd64;
        run_windows("clamp", 31, 12'd4095);
        vectors++;
        if (gain !== 10'd16 || sat_lo !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp31: gain %0d lo %b want 16 0", gain, sat_lo);
        end
        run_windows("clamp", 1, 12'd4095);
        vectors++;
        if (gain !== 10'd0 || sat_lo !== 1'b1 || sat_hi !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp32: gain %0d lo %b hi %b want 0 1 0", gain, sat_lo, sat_hi);
        end
        run_windows("clamp_hold", 2, 12'd4095);
        vectors++;
        if (gain !== 10'd0 || sat_lo !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_hold: gain %0d lo %b want 0 1", gain, sat_lo);
        end
    endtask

    task automatic test_lock();
        do_reset();
        target = 12'd1024;
        hyst   = 12'd64;
        run_windows("lock", 3, 12'd1024);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lock3: locked got %b want 0", locked);
        end
        run_windows("lock", 1, 12'd1024);
        vectors++;
        if (locked !== 1'b1 || gain !== 10'd512) begin
            miscompares++;
            $display("FAIL lock4: locked %b gain %0d want 1 512", locked, gain);
        end
        run_windows("unlock", 1, 12'd1200);
        vectors++;
        if (locked !== 1'b0 || gain !== 10'd496) begin
            miscompares++;
            $display("FAIL unlock: locked %b gain %0d want 0 496", locked, gain);
        end
        run_windows("relock", 3, 12'd1024);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL relock3: locked got %b want 0", locked);
        end
    endtask

    task automatic test_freeze_edge();
        freeze = 1'b1;
        run_windows("freeze", 1, 12'd2000);
        vectors++;
        if (gain !== 10'd496) begin
            miscompares++;
            $display("FAIL freeze: gain got %0d want 496", gain);
        end
        freeze = 1'b0;
        target = 12'd4090;
        hyst   = 12'd64;
        run_windows("band_edge", 1, 12'd4095);
        vectors++;
        if (gain !== 10'd496) begin
            miscompares++;
            $display("FAIL band_edge: gain got %0d want 496", gain);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        target = 12'd1024;
        hyst   = 12'd64;
        for (int i = 0; i < 8; i++) step(1'b1, 12'd4095);
        i_rst = 1'b0;
        step(1'b1, 12'd4095);
        i_rst = 1'b1;
        run_windows("reset_mid", 1, 12'd100);
        vectors++;
        if (gain !== 10'd514 || win_cycles != WIN + 2) begin
            miscompares++;
            $display("FAIL reset_mid: gain %0d len %0d want 514 %0d", gain, win_cycles, WIN + 2);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                target = 12'($urandom_range(0, 4095));
                hyst   = 12'($urandom_range(0, 400));
            end
            if ($urandom_range(0, 29) == 0) freeze = ~freeze;
            i_rst = ($urandom_range(0, 499) != 0);
            step($urandom_range(0, 3) != 0, 12'($urandom_range(0, 4095)));
            vectors++;
            if ({gain, gain_valid, locked, sat_hi, sat_lo} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: gain/gv/lk/hi/lo got %h want %h", i,
                         {gain, gain_valid, locked, sat_hi, sat_lo}, exp_vec());
            end
        end
        i_rst  = 1'b1;
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_clamp();
        test_lock();
        test_freeze_edge();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
